// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage that owns the PC, addresses inst_mem
// and captures the returned instruction into the IF/ID pipeline register.
// Optional macro FETCH_PERF_CNT_EN adds fetch/stall performance counters.
`timescale 1ns/1ps

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              redirect_valid_i,
  input  logic [31:0]       redirect_target_i,
  output logic [31:0]       inst_addr_o,
  input  logic [31:0]       inst_i,
`ifdef FETCH_PERF_CNT_EN
  output logic [CNT_W-1:0]  fetch_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
`endif
  output logic [31:0]       if_id_pc_o,
  output logic [31:0]       if_id_pc_plus4_o,
  output logic [31:0]       if_id_inst_o,
  output logic              if_id_valid_o,
  output logic              misaligned_o,
  output logic              halted_o
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;

  state_t          state_q, state_nxt;
  logic [XLEN-1:0] pc_q, pc_nxt;
  logic [XLEN-1:0] pc_plus4;
  if_id_t          if_id_q, if_id_nxt;
  logic            misaligned_q, misaligned_nxt;
  logic            halted_q;

  assign pc_plus4 = pc_q + XLEN'(4);

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      if_id_q      <= '{pc: '0, pc_plus4: '0, inst: NOP_INST, valid: 1'b0};
      misaligned_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      pc_q         <= pc_nxt;
      if_id_q      <= if_id_nxt;
      misaligned_q <= misaligned_nxt;
      halted_q     <= (state_nxt == HALTED);
    end
  end

  // Next-state logic: redirect beats stall beats advance; bubbles keep pc fields.
  always_comb begin
    state_nxt      = state_q;
    pc_nxt         = pc_q;
    if_id_nxt      = if_id_q;
    misaligned_nxt = 1'b0;

    if (redirect_valid_i) begin
      pc_nxt          = {redirect_target_i[XLEN-1:2], 2'b00};
      if_id_nxt.inst  = NOP_INST;
      if_id_nxt.valid = 1'b0;
      misaligned_nxt  = |redirect_target_i[1:0];
      state_nxt       = RUN;
    end else begin
      case (state_q)
        BOOT: begin
          if_id_nxt.inst  = NOP_INST;
          if_id_nxt.valid = 1'b0;
          state_nxt       = RUN;
        end
        RUN: begin
          if (!stall_i) begin
            if_id_nxt = '{pc: pc_q, pc_plus4: pc_plus4, inst: inst_i, valid: 1'b1};
            if (inst_i == EBREAK_INST) begin
              state_nxt = HALTED;
            end else begin
              pc_nxt = pc_plus4;
            end
          end
        end
        HALTED: begin
          if_id_nxt.inst  = NOP_INST;
          if_id_nxt.valid = 1'b0;
        end
        default: begin
          state_nxt = BOOT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q, stall_cnt_q;

  // Performance counters: valid IF/ID loads and genuine RUN stall cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == RUN && !redirect_valid_i && !stall_i) begin
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      end
      if (state_q == RUN && !redirect_valid_i && stall_i) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

  assign inst_addr_o      = pc_q;
  assign if_id_pc_o       = if_id_q.pc;
  assign if_id_pc_plus4_o = if_id_q.pc_plus4;
  assign if_id_inst_o     = if_id_q.inst;
  assign if_id_valid_o    = if_id_q.valid;
  assign misaligned_o     = misaligned_q;
  assign halted_o         = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a small
// combinational inst_mem model.
`timescale 1ns/1ps

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc_plus4_o;
  logic [31:0] if_id_inst_o;
  logic        if_id_valid_o;
  logic        misaligned_o;
  logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .inst_addr_o       (inst_addr_o),
    .inst_i            (inst_i),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt_o       (fetch_cnt_o),
    .stall_cnt_o       (stall_cnt_o),
`endif
    .if_id_pc_o        (if_id_pc_o),
    .if_id_pc_plus4_o  (if_id_pc_plus4_o),
    .if_id_inst_o      (if_id_inst_o),
    .if_id_valid_o     (if_id_valid_o),
    .misaligned_o      (misaligned_o),
    .halted_o          (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preloaded instruction memory contents.
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_read = 32'h0050_0093;
      32'h0000_0004: mem_read = 32'h00A0_0113;
      32'h0000_0008: mem_read = 32'h0020_81B3;
      32'h0000_000C: mem_read = 32'h0030_8233;
      32'h0000_0010: mem_read = 32'h0010_0073;
      32'h0000_0040: mem_read = 32'h0010_0093;
      default:       mem_read = 32'h0000_0033;
    endcase
  endfunction

  always_comb inst_i = mem_read(inst_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                          input logic [31:0] inst, input logic valid);
    chk({tag, ".pc"},    if_id_pc_o,       pc);
    chk({tag, ".pc4"},   if_id_pc_plus4_o, pc4);
    chk({tag, ".inst"},  if_id_inst_o,     inst);
    chk({tag, ".valid"}, 32'(if_id_valid_o), 32'(valid));
  endtask

  initial begin
    reset_n           = 1'b0;
    stall_i           = 1'b0;
    redirect_valid_i  = 1'b0;
    redirect_target_i = 32'h0;
    step();
    step();

    // Reset state.
    chk("rst.addr", inst_addr_o, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, NOP, 1'b0);
    chk("rst.mis",  32'(misaligned_o), 32'h0);
    chk("rst.halt", 32'(halted_o), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst.fcnt", fetch_cnt_o, 32'h0);
    chk("rst.scnt", stall_cnt_o, 32'h0);
`endif

    // BOOT cycle: PC held, bubble loaded.
    reset_n = 1'b1;
    step();
    chk("boot.addr", inst_addr_o, 32'h0);
    chk_ifid("boot", 32'h0, 32'h0, NOP, 1'b0);

    // Sequential fetch of 0,4.
    step();
    chk("f0.addr", inst_addr_o, 32'h4);
    chk_ifid("f0", 32'h0, 32'h4, 32'h0050_0093, 1'b1);
    step();
    chk("f4.addr", inst_addr_o, 32'h8);
    chk_ifid("f4", 32'h4, 32'h8, 32'h00A0_0113, 1'b1);

    // Two-cycle stall at pc=8.
    stall_i = 1'b1;
    step();
    chk("st1.addr", inst_addr_o, 32'h8);
    chk("st1.pc",   if_id_pc_o,  32'h4);
    step();
    chk("st2.addr", inst_addr_o, 32'h8);
    chk_ifid("st2", 32'h4, 32'h8, 32'h00A0_0113, 1'b1);
    stall_i = 1'b0;
    step();
    chk("f8.addr", inst_addr_o, 32'hC);
    chk_ifid("f8", 32'h8, 32'hC, 32'h0020_81B3, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    chk("run.scnt", stall_cnt_o, 32'h2);
    chk("run.fcnt", fetch_cnt_o, 32'h3);
`endif

    // Redirect to 0x40 while stalled: redirect wins, pc fields kept.
    stall_i           = 1'b1;
    redirect_valid_i  = 1'b1;
    redirect_target_i = 32'h40;
    step();
    chk("rds.addr", inst_addr_o, 32'h40);
    chk_ifid("rds", 32'h8, 32'hC, NOP, 1'b0);
    chk("rds.mis", 32'(misaligned_o), 32'h0);
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    step();
    chk("f40.addr", inst_addr_o, 32'h44);
    chk_ifid("f40", 32'h40, 32'h44, 32'h0010_0093, 1'b1);

    // Misaligned redirect to 0x42.
    redirect_valid_i  = 1'b1;
    redirect_target_i = 32'h42;
    step();
    chk("mis.addr",  inst_addr_o, 32'h40);
    chk("mis.pulse", 32'(misaligned_o), 32'h1);
    chk("mis.valid", 32'(if_id_valid_o), 32'h0);
    redirect_valid_i = 1'b0;
    step();
    chk("mis.clear", 32'(misaligned_o), 32'h0);
    chk("mis.addr2", inst_addr_o, 32'h44);
    chk("mis.pc",    if_id_pc_o,  32'h40);

    // EBREAK at 0x10.
    redirect_valid_i  = 1'b1;
    redirect_target_i = 32'h10;
    step();
    chk("rd10.addr", inst_addr_o, 32'h10);
    redirect_valid_i = 1'b0;
    step();
    chk_ifid("ebrk", 32'h10, 32'h14, 32'h0010_0073, 1'b1);
    chk("ebrk.addr", inst_addr_o, 32'h10);
    chk("ebrk.halt", 32'(halted_o), 32'h1);
    stall_i = 1'b1;
    step();
    chk("hlt.addr", inst_addr_o, 32'h10);
    chk("hlt.halt", 32'(halted_o), 32'h1);
    chk_ifid("hlt", 32'h10, 32'h14, NOP, 1'b0);
    stall_i           = 1'b0;
    redirect_valid_i  = 1'b1;
    redirect_target_i = 32'h0;
    step();
    chk("unh.halt", 32'(halted_o), 32'h0);
    chk("unh.addr", inst_addr_o, 32'h0);
    chk("unh.valid", 32'(if_id_valid_o), 32'h0);
    redirect_valid_i = 1'b0;
    step();
    chk_ifid("re0", 32'h0, 32'h4, 32'h0050_0093, 1'b1);
    step();
    step();
    chk("pre.addr", inst_addr_o, 32'hC);

    // Asynchronous reset pulse mid-run at pc=0x0C.
    reset_n = 1'b0;
    #1;
    chk("arst.addr", inst_addr_o, 32'h0);
    chk_ifid("arst", 32'h0, 32'h0, NOP, 1'b0);
    chk("arst.halt", 32'(halted_o), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("arst.fcnt", fetch_cnt_o, 32'h0);
    chk("arst.scnt", stall_cnt_o, 32'h0);
`endif
    #1;
    reset_n = 1'b1;
    step();
    chk("boot2.addr",  inst_addr_o, 32'h0);
    chk("boot2.valid", 32'(if_id_valid_o), 32'h0);
    step();
    step();
    step();
    chk("post.addr", inst_addr_o, 32'hC);
    chk_ifid("post", 32'h8, 32'hC, 32'h0020_81B3, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    chk("post.fcnt", fetch_cnt_o, 32'h3);
    chk("post.scnt", stall_cnt_o, 32'h0);
`endif

    // PC wrap from 0xFFFF_FFFC to 0.
    redirect_valid_i  = 1'b1;
    redirect_target_i = 32'hFFFF_FFFC;
    step();
    chk("wrp.addr", inst_addr_o, 32'hFFFF_FFFC);
    redirect_valid_i = 1'b0;
    step();
    chk("wrp.addr2", inst_addr_o, 32'h0);
    chk_ifid("wrp", 32'hFFFF_FFFC, 32'h0, 32'h0000_0033, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of inst_mem.
- Owns the program counter and drives the byte address into inst_mem.
- Captures the returned instruction into an IF/ID pipeline register for decode.
- Handles stall, redirect (branch/jump/trap), a post-reset boot cycle, and halt-on-EBREAK.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/halt/reset.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, all flops rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold PC and IF/ID this cycle.
- redirect_valid_i  in  1  load PC from redirect_target_i and flush IF/ID.
- redirect_target_i  in  32  redirect byte address.
- inst_addr_o  out  32  byte address to inst_mem; equals the PC register.
- inst_i  in  32  instruction from inst_mem; combinational, same cycle.
- if_id_pc_o  out  32  PC of the captured instruction.
- if_id_pc_plus4_o  out  32  captured PC+4.
- if_id_inst_o  out  32  captured instruction.
- if_id_valid_o  out  1  captured instruction is real (not a bubble).
- misaligned_o  out  1  one-cycle pulse: last redirect target had [1:0]!=0.
- halted_o  out  1  fetch halted on EBREAK.

Behaviour:
- Reset values (async on reset_n low):
  - pc = RESET_PC; state = BOOT.
  - if_id_pc_o = 0; if_id_pc_plus4_o = 0; if_id_inst_o = NOP_INST.
  - if_id_valid_o = 0; misaligned_o = 0; halted_o = 0.
- inst_addr_o is always the PC register, with no added logic. The instruction at inst_addr_o is captured at the next edge, so fetch-to-IF/ID latency is 1 cycle.
- States: BOOT, RUN, HALTED.
- BOOT: one cycle. PC holds RESET_PC, IF/ID loads bubble (NOP_INST, valid=0), next state RUN. Redirect in BOOT is applied (see Redirect) and the next state is RUN.
- RUN, priority redirect > stall > advance:
  - Redirect: pc <= {redirect_target_i[31:2],2'b00}; IF/ID <= bubble; misaligned_o <= |redirect_target_i[1:0], else 0.
  - Stall: PC and all IF/ID fields hold; misaligned_o <= 0.
  - Advance: pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0). IF/ID <= {pc, pc+4, inst_i, valid=1}.
  - Advance with inst_i == 32'h0010_0073 (EBREAK): capture as a normal valid instruction, PC holds (does not increment), next state HALTED.
- HALTED:
  - halted_o = 1 (registered, equals state==HALTED).
  - PC holds; IF/ID <= bubble each cycle.
  - stall_i is ignored.
  - redirect_valid_i performs a redirect and the next state is RUN.
- misaligned_o is high for exactly the cycle after a misaligned redirect, and 0 otherwise.
- A redirect during stall wins: PC is loaded and IF/ID is flushed.
- Reset asserted mid-operation immediately forces all reset values, regardless of state, stall or redirect.
- if_id_pc_plus4_o is always if_id_pc_o+4 when valid=1, and 0 for bubbles generated by reset. Bubbles from flush/halt keep the previous pc fields; only inst and valid change.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt_o[CNT_W-1:0] and stall_cnt_o[CNT_W-1:0], both reset to 0.
  - fetch_cnt_o increments on every cycle that loads IF/ID with valid=1.
  - stall_cnt_o increments on every RUN cycle with stall_i=1 and redirect_valid_i=0.
  - Both wrap at 2^CNT_W.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then release with inst_mem preloaded (addr0=0x00500093, addr4=0x00A00113, addr8=0x002081B3):
  - inst_addr_o=0 through BOOT; then 0,4,8.
  - if_id valid=0 in the BOOT cycle.
  - Following edges capture (pc=0,inst=0x00500093), (pc=4,0x00A00113), (pc=8,0x002081B3).
- stall_i high 2 cycles with pc=8 -> inst_addr_o stays 8, if_id_pc_o stays 4 for both cycles; resumes capturing pc=8 on release.
- redirect_valid_i with target 0x40 while stalled -> next cycle inst_addr_o=0x40, if_id_inst_o=0x00000013, valid=0, misaligned_o=0.
- redirect to 0x42 -> inst_addr_o=0x40, misaligned_o=1 for exactly one cycle.
- EBREAK at address 0x10 -> if_id_inst_o=0x00100073 valid=1, then halted_o=1 and inst_addr_o held at 0x10 with bubbles. A redirect to 0x0 clears halted_o and refetches from 0.
- reset_n pulsed low mid-run at pc=0x0C -> outputs reset immediately (asynchronously), inst_addr_o=RESET_PC. With FETCH_PERF_CNT_EN, counters return to 0 and count 3 fetches over the next 4 cycles.
